// File: rtl/gpio_cfg_pkg.sv
// Shared constants for the GPIO pad configuration shift chain: widths, pad-field bit map, FSM states.
package gpio_cfg_pkg;

  localparam int CFG_W = 13;
  localparam int DM_W  = 3;

  localparam int MGMT_ENA_BIT      = 0;
  localparam int OUTENB_BIT        = 1;
  localparam int HOLDOVER_BIT      = 2;
  localparam int INP_DIS_BIT       = 3;
  localparam int IB_MODE_SEL_BIT   = 4;
  localparam int ANA_EN_BIT        = 5;
  localparam int ANA_SEL_BIT       = 6;
  localparam int ANA_POL_BIT       = 7;
  localparam int SLOW_SEL_BIT      = 8;
  localparam int VTRIP_SEL_BIT     = 9;
  localparam int DM_LSB            = 10;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } cfg_state_t;

endpackage

// File: rtl/gpio_cfg_shreg.sv
// Serial-in shift register with pass-through output and a bit counter saturating at CFG_W.
// One shift per enabled cycle; no backpressure, the counter clear wins over an increment.
module gpio_cfg_shreg #(
  parameter int CFG_W = 13,
  localparam int CNT_W = $clog2(CFG_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             reload,
  input  logic [CFG_W-1:0] defaults,
  input  logic             shift_en,
  input  logic             data_in,
  input  logic             cnt_clr,
  output logic [CFG_W-1:0] shift_reg,
  output logic             data_out,
  output logic [CNT_W-1:0] bit_cnt,
  output logic             cnt_full
);

  assign cnt_full = (bit_cnt == CNT_W'(CFG_W));

  always_ff @(posedge clk) begin
    if (rst) begin
      shift_reg <= defaults;
      data_out  <= 1'b0;
      bit_cnt   <= '0;
    end else if (reload) begin
      shift_reg <= defaults;
      bit_cnt   <= '0;
    end else begin
      if (shift_en) begin
        shift_reg <= {shift_reg[CFG_W-2:0], data_in};
        data_out  <= shift_reg[CFG_W-1];
      end
      // A load always restarts the count, even when it coincides with a shift.
      if (cnt_clr)
        bit_cnt <= '0;
      else if (shift_en && !cnt_full)
        bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

endmodule

// File: rtl/gpio_cfg_shift.sv
// GPIO pad configuration loader: serial chain, IDLE/SHIFT/COMMIT FSM and shadow cfg register.
// Commit lands one cycle after serial_load; no backpressure, inputs are accepted every cycle.
module gpio_cfg_shift
  import gpio_cfg_pkg::*;
#(
  parameter int CFG_W = gpio_cfg_pkg::CFG_W
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [CFG_W-1:0] gpio_defaults,
  input  logic             defaults_reload,
  input  logic             serial_shift_en,
  input  logic             serial_data_in,
  input  logic             serial_load,
  output logic             serial_data_out,
  output logic [CFG_W-1:0] cfg,
  output logic             mgmt_ena,
  output logic             gpio_outenb,
  output logic             gpio_holdover,
  output logic             gpio_inp_dis,
  output logic             gpio_ib_mode_sel,
  output logic             gpio_ana_en,
  output logic             gpio_ana_sel,
  output logic             gpio_ana_pol,
  output logic             gpio_slow_sel,
  output logic             gpio_vtrip_sel,
  output logic [DM_W-1:0]  gpio_dm,
  output logic             cfg_busy,
  output logic             cfg_err
);

  localparam int CNT_W = $clog2(CFG_W + 1);

  cfg_state_t       state;
  logic [CFG_W-1:0] shift_reg;
  logic [CNT_W-1:0] bit_cnt;
  logic             cnt_full;

  gpio_cfg_shreg #(.CFG_W(CFG_W)) u_shreg (
    .clk       (wb_clk_i),
    .rst       (wb_rst_i),
    .reload    (defaults_reload),
    .defaults  (gpio_defaults),
    .shift_en  (serial_shift_en),
    .data_in   (serial_data_in),
    .cnt_clr   (serial_load),
    .shift_reg (shift_reg),
    .data_out  (serial_data_out),
    .bit_cnt   (bit_cnt),
    .cnt_full  (cnt_full)
  );

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i || defaults_reload) begin
      state    <= ST_IDLE;
      cfg_busy <= 1'b0;
      cfg      <= gpio_defaults;
      cfg_err  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_SHIFT: begin
          if (serial_shift_en) begin
            state    <= ST_SHIFT;
            cfg_busy <= 1'b1;
          end else if (serial_load) begin
            state    <= ST_COMMIT;
            cfg_busy <= 1'b0;
          end else begin
            state    <= ST_IDLE;
            cfg_busy <= 1'b0;
          end
        end
        default: begin
          state    <= ST_IDLE;
          cfg_busy <= 1'b0;
        end
      endcase
      // Only a clean load of a full word reaches the pads; anything else is latched as an error.
      if (serial_load) begin
        if (!serial_shift_en && cnt_full)
          cfg <= shift_reg;
        else
          cfg_err <= 1'b1;
      end
    end
  end

  assign mgmt_ena         = cfg[MGMT_ENA_BIT];
  assign gpio_outenb      = cfg[OUTENB_BIT];
  assign gpio_holdover    = cfg[HOLDOVER_BIT];
  assign gpio_inp_dis     = cfg[INP_DIS_BIT];
  assign gpio_ib_mode_sel = cfg[IB_MODE_SEL_BIT];
  assign gpio_ana_en      = cfg[ANA_EN_BIT];
  assign gpio_ana_sel     = cfg[ANA_SEL_BIT];
  assign gpio_ana_pol     = cfg[ANA_POL_BIT];
  assign gpio_slow_sel    = cfg[SLOW_SEL_BIT];
  assign gpio_vtrip_sel   = cfg[VTRIP_SEL_BIT];
  assign gpio_dm          = cfg[DM_LSB +: DM_W];

endmodule

// File: tb/tb_gpio_cfg_shift.sv
// Directed bench for gpio_cfg_shift: reset, load, error, overshift, mid-shift reset, reload priority.
module tb_gpio_cfg_shift;
  import gpio_cfg_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] defaults;
  logic        reload, shift_en, data_in, load;
  logic        data_out;
  logic [12:0] cfg;
  logic        mgmt_ena, outenb, holdover, inp_dis, ib_mode_sel, ana_en, ana_sel, ana_pol;
  logic        slow_sel, vtrip_sel, busy, err;
  logic [2:0]  dm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  gpio_cfg_shift dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .gpio_defaults(defaults), .defaults_reload(reload),
    .serial_shift_en(shift_en), .serial_data_in(data_in), .serial_load(load),
    .serial_data_out(data_out), .cfg(cfg), .mgmt_ena(mgmt_ena), .gpio_outenb(outenb),
    .gpio_holdover(holdover), .gpio_inp_dis(inp_dis), .gpio_ib_mode_sel(ib_mode_sel),
    .gpio_ana_en(ana_en), .gpio_ana_sel(ana_sel), .gpio_ana_pol(ana_pol),
    .gpio_slow_sel(slow_sel), .gpio_vtrip_sel(vtrip_sel), .gpio_dm(dm),
    .cfg_busy(busy), .cfg_err(err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [15:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) begin
      shift_en = 1'b1;
      data_in  = val[i];
      tick();
    end
    shift_en = 1'b0;
    data_in  = 1'b0;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++; if (cfg !== 13'h1803) begin errors++; $display("FAIL reset_cfg got %h want 1803", cfg); end
    checks++; if (mgmt_ena !== 1'b1 || outenb !== 1'b1) begin errors++; $display("FAIL reset_fields got %b%b want 11", mgmt_ena, outenb); end
    checks++; if (dm !== 3'b110) begin errors++; $display("FAIL reset_dm got %b want 110", dm); end
    checks++; if (err !== 1'b0 || busy !== 1'b0 || data_out !== 1'b0) begin errors++; $display("FAIL reset_flags err/busy/sdo got %b%b%b want 000", err, busy, data_out); end
  endtask

  task automatic test_valid_load();
    shift_en = 1'b1; data_in = 1'b0;
    tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_during_shift got %b want 1", busy); end
    shift_bits(16'h0403, 12);
    checks++; if (dut.bit_cnt !== 4'd13) begin errors++; $display("FAIL bitcnt_full got %0d want 13", dut.bit_cnt); end
    pulse_load();
    checks++; if (cfg !== 13'h0403) begin errors++; $display("FAIL valid_cfg got %h want 0403", cfg); end
    checks++; if (dm !== 3'b001 || mgmt_ena !== 1'b1 || outenb !== 1'b1) begin errors++; $display("FAIL valid_fields dm %b me %b oe %b want 001 1 1", dm, mgmt_ena, outenb); end
    checks++; if (busy !== 1'b0 || err !== 1'b0) begin errors++; $display("FAIL valid_flags busy/err got %b%b want 00", busy, err); end
    checks++; if (dut.state !== ST_COMMIT) begin errors++; $display("FAIL commit_state got %0d want %0d", dut.state, ST_COMMIT); end
    tick();
    checks++; if (dut.state !== ST_IDLE || dut.bit_cnt !== 4'd0) begin errors++; $display("FAIL after_commit state %0d cnt %0d want 0 0", dut.state, dut.bit_cnt); end
  endtask

  task automatic test_short_load();
    shift_bits(16'h007F, 7);
    pulse_load();
    checks++; if (cfg !== 13'h0403) begin errors++; $display("FAIL short_cfg got %h want 0403", cfg); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err); end
    checks++; if (dut.bit_cnt !== 4'd0) begin errors++; $display("FAIL short_cnt got %0d want 0", dut.bit_cnt); end
    tick();
    shift_bits(16'h1555, 13);
    pulse_load();
    checks++; if (cfg !== 13'h1555) begin errors++; $display("FAIL err_then_valid_cfg got %h want 1555", cfg); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got %b want 1", err); end
    tick();
    reload = 1'b1;
    tick();
    reload = 1'b0;
    checks++; if (cfg !== 13'h1803 || err !== 1'b0) begin errors++; $display("FAIL reload_clear cfg %h err %b want 1803 0", cfg, err); end
  endtask

  task automatic test_overshift();
    logic [14:0] word;
    logic [14:0] exp_out;
    word    = 15'h4A5A;
    exp_out = {13'h1803, 2'b10};
    for (int k = 0; k < 15; k++) begin
      shift_en = 1'b1;
      data_in  = word[14-k];
      tick();
      checks++; if (data_out !== exp_out[14-k]) begin errors++; $display("FAIL overshift_sdo shift %0d got %b want %b", k, data_out, exp_out[14-k]); end
    end
    shift_en = 1'b0;
    checks++; if (dut.bit_cnt !== 4'd13) begin errors++; $display("FAIL overshift_cnt got %0d want 13", dut.bit_cnt); end
    pulse_load();
    checks++; if (cfg !== 13'h0A5A || err !== 1'b0) begin errors++; $display("FAIL overshift_cfg cfg %h err %b want 0a5a 0", cfg, err); end
    tick();
  endtask

  task automatic test_reset_mid_shift();
    shift_bits(16'h003F, 6);
    rst = 1'b1; shift_en = 1'b1; data_in = 1'b1;
    tick();
    rst = 1'b0; shift_en = 1'b0; data_in = 1'b0;
    checks++; if (dut.state !== ST_IDLE || busy !== 1'b0) begin errors++; $display("FAIL midrst_state got %0d busy %b want 0 0", dut.state, busy); end
    checks++; if (cfg !== 13'h1803 || dut.bit_cnt !== 4'd0 || data_out !== 1'b0) begin errors++; $display("FAIL midrst_regs cfg %h cnt %0d sdo %b want 1803 0 0", cfg, dut.bit_cnt, data_out); end
    shift_bits(16'h1234, 13);
    pulse_load();
    checks++; if (cfg !== 13'h1234 || err !== 1'b0) begin errors++; $display("FAIL midrst_reload cfg %h err %b want 1234 0", cfg, err); end
    tick();
  endtask

  task automatic test_load_with_shift();
    shift_bits(16'h0F0F, 12);
    shift_en = 1'b1; data_in = 1'b1; load = 1'b1;
    tick();
    shift_en = 1'b0; data_in = 1'b0; load = 1'b0;
    checks++; if (cfg !== 13'h1234 || err !== 1'b1) begin errors++; $display("FAIL loadshift cfg %h err %b want 1234 1", cfg, err); end
    checks++; if (busy !== 1'b1 || dut.bit_cnt !== 4'd0) begin errors++; $display("FAIL loadshift_state busy %b cnt %0d want 1 0", busy, dut.bit_cnt); end
    tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL loadshift_idle busy %b want 0", busy); end
    shift_bits(16'h0777, 13);
    load = 1'b1; reload = 1'b1;
    tick();
    load = 1'b0; reload = 1'b0;
    checks++; if (cfg !== 13'h1803 || err !== 1'b0) begin errors++; $display("FAIL reload_over_load cfg %h err %b want 1803 0", cfg, err); end
    checks++; if (dut.state !== ST_IDLE || dut.bit_cnt !== 4'd0) begin errors++; $display("FAIL reload_over_load_state %0d cnt %0d want 0 0", dut.state, dut.bit_cnt); end
  endtask

  initial begin
    rst = 1'b1; defaults = 13'h1803; reload = 1'b0;
    shift_en = 1'b0; data_in = 1'b0; load = 1'b0;
    test_reset();
    test_valid_load();
    test_short_load();
    test_overshift();
    test_reset_mid_shift();
    test_load_with_shift();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
